// File: rtl/display_pkg.sv
// display_pkg: segment type, decode table and BCD-to-segment helper.
// HEX_DECODE_EN selects hex glyphs for codes 10..15 instead of a dash.
package display_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_OFF = 7'b0000000;
  localparam seg_t SEG_DASH = 7'b0000001;
  localparam seg_t SEG_DIGIT [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011,
`ifdef HEX_DECODE_EN
    7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
`else
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
`endif
  };
  function automatic seg_t bcd_to_seg(input logic [3:0] code);
    return SEG_DIGIT[code];
  endfunction
endpackage

// File: rtl/display_scan_timer.sv
// display_scan_timer: per-digit slot counter, digit index and end-of-frame pulse.
module display_scan_timer #(
  parameter int DIGITS = 4,
  parameter int REFRESH_CYCLES = 10000,
  parameter int BLANK_CYCLES = 16,
  localparam int CW = $clog2(REFRESH_CYCLES),
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic [CW-1:0] count,
  output logic [IW-1:0] index,
  output logic          blank,
  output logic          frame_done
);
  logic wrap, last;
  assign wrap = count == CW'(REFRESH_CYCLES - 1);
  assign last = index == IW'(DIGITS - 1);
  assign blank = int'(count) < BLANK_CYCLES;
  always_ff @(posedge clk) begin
    if (!reset || !run) begin
      count <= '0;
      index <= '0;
      frame_done <= 1'b0;
    end else begin
      count <= wrap ? '0 : count + CW'(1);
      index <= wrap ? (last ? '0 : index + IW'(1)) : index;
      frame_done <= wrap && last;
    end
  end
endmodule

// File: rtl/display_mux_n.sv
// display_mux_n: N-digit multiplexed 7-segment driver with blanking and leading-zero suppression.
// HEX_DECODE_EN (via display_pkg) renders codes 10..15 as hex glyphs.
module display_mux_n
  import display_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int REFRESH_CYCLES = 10000,
  parameter int BLANK_CYCLES = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_BCD,
  input  logic [4*DIGITS-1:0] BCD_code,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                blank_lz,
  output logic [6:0]          segments,
  output logic                dp,
  output logic [DIGITS-1:0]   display_select,
  output logic                frame_done
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam seg_t SEG_POL = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic DP_POL = SEG_ACTIVE_LOW != 0;
  localparam logic [DIGITS-1:0] SEL_POL = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
  logic [4*DIGITS-1:0] code;
  logic [DIGITS-1:0] dp_latch;
  logic loaded, blank, show, lz, dp_next;
  logic [CW-1:0] count;
  logic [IW-1:0] index;
  logic [3:0] digit;
  seg_t seg_next;
  logic [DIGITS-1:0] sel_next;
  display_scan_timer #(
    .DIGITS(DIGITS), .REFRESH_CYCLES(REFRESH_CYCLES), .BLANK_CYCLES(BLANK_CYCLES)
  ) timer (
    .clk(clk), .reset(reset), .run(loaded),
    .count(count), .index(index), .blank(blank), .frame_done(frame_done)
  );
  // A digit is a leading zero when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    digit = code[4*index +: 4];
    lz = blank_lz && index != '0 && (code >> (4*index)) == '0;
    show = loaded && !blank;
    seg_next = (show && !lz) ? bcd_to_seg(digit) : SEG_OFF;
    sel_next = show ? (DIGITS'(1) << index) : '0;
    dp_next = show && dp_latch[index];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      code <= '0;
      dp_latch <= '0;
      loaded <= 1'b0;
      segments <= SEG_POL;
      dp <= DP_POL;
      display_select <= SEL_POL;
    end else begin
      if (valid_BCD) begin
        code <= BCD_code;
        dp_latch <= dp_in;
        loaded <= 1'b1;
      end
      segments <= seg_next ^ SEG_POL;
      dp <= dp_next ^ DP_POL;
      display_select <= sel_next ^ SEL_POL;
    end
  end
endmodule

// File: tb/tb_display_mux_n.sv
// tb_display_mux_n: directed table-driven checks of display_mux_n plus multi-cycle sequences.
module tb_display_mux_n;
  logic clk = 1'b0, reset = 1'b0, valid_BCD = 1'b0, blank_lz = 1'b0;
  logic [15:0] BCD_code = '0;
  logic [3:0] dp_in = '0;
  logic [6:0] segments;
  logic dp, frame_done;
  logic [3:0] display_select;
  int errors = 0, checks = 0;
`ifdef HEX_DECODE_EN
  localparam logic [6:0] SEG_XA = 7'b1110111, SEG_XB = 7'b0011111;
`else
  localparam logic [6:0] SEG_XA = 7'b0000001, SEG_XB = 7'b0000001;
`endif
  typedef struct {
    logic [15:0] code;
    logic [3:0] dpi;
    logic lz;
    int k;
    logic [3:0] sel;
    logic [6:0] seg;
    logic d;
  } vec_t;
  localparam int NV = 26;
  vec_t tv [NV];

  always #5 clk = ~clk;

  display_mux_n #(
    .DIGITS(4), .REFRESH_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .valid_BCD(valid_BCD), .BCD_code(BCD_code), .dp_in(dp_in),
    .blank_lz(blank_lz), .segments(segments), .dp(dp), .display_select(display_select),
    .frame_done(frame_done)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] s, input logic [6:0] g, input logic d);
    check(name, {display_select, segments, dp}, {s, g, d});
  endtask

  // Leaves the bench just after the capture edge: output k cycles later is digit ((k-1)/8)%4, slot phase (k-1)%8.
  task automatic load(input logic [15:0] c, input logic [3:0] d, input logic lz);
    reset = 1'b0;
    valid_BCD = 1'b0;
    step();
    reset = 1'b1;
    blank_lz = lz;
    BCD_code = c;
    dp_in = d;
    valid_BCD = 1'b1;
    step();
    valid_BCD = 1'b0;
  endtask

  initial begin
    tv[0]  = '{16'h1234, 4'b0000, 1'b0, 1,  4'b1111, 7'b0000000, 1'b0};
    tv[1]  = '{16'h1234, 4'b0000, 1'b0, 3,  4'b1110, 7'b0110011, 1'b0};
    tv[2]  = '{16'h1234, 4'b0000, 1'b0, 8,  4'b1110, 7'b0110011, 1'b0};
    tv[3]  = '{16'h1234, 4'b0000, 1'b0, 9,  4'b1111, 7'b0000000, 1'b0};
    tv[4]  = '{16'h1234, 4'b0000, 1'b0, 11, 4'b1101, 7'b1111001, 1'b0};
    tv[5]  = '{16'h1234, 4'b0000, 1'b0, 19, 4'b1011, 7'b1101101, 1'b0};
    tv[6]  = '{16'h1234, 4'b0000, 1'b0, 27, 4'b0111, 7'b0110000, 1'b0};
    tv[7]  = '{16'h1234, 4'b0000, 1'b0, 33, 4'b1111, 7'b0000000, 1'b0};
    tv[8]  = '{16'h1234, 4'b0000, 1'b0, 35, 4'b1110, 7'b0110011, 1'b0};
    tv[9]  = '{16'h0050, 4'b0000, 1'b1, 3,  4'b1110, 7'b1111110, 1'b0};
    tv[10] = '{16'h0050, 4'b0000, 1'b1, 11, 4'b1101, 7'b1011011, 1'b0};
    tv[11] = '{16'h0050, 4'b0000, 1'b1, 19, 4'b1011, 7'b0000000, 1'b0};
    tv[12] = '{16'h0050, 4'b0000, 1'b1, 27, 4'b0111, 7'b0000000, 1'b0};
    tv[13] = '{16'h0050, 4'b0000, 1'b0, 19, 4'b1011, 7'b1111110, 1'b0};
    tv[14] = '{16'h0050, 4'b0000, 1'b0, 27, 4'b0111, 7'b1111110, 1'b0};
    tv[15] = '{16'h00A0, 4'b0010, 1'b0, 11, 4'b1101, SEG_XA,     1'b1};
    tv[16] = '{16'h00A0, 4'b0010, 1'b0, 3,  4'b1110, 7'b1111110, 1'b0};
    tv[17] = '{16'h00A0, 4'b0010, 1'b0, 10, 4'b1111, 7'b0000000, 1'b0};
    tv[18] = '{16'h0000, 4'b1000, 1'b1, 3,  4'b1110, 7'b1111110, 1'b0};
    tv[19] = '{16'h0000, 4'b1000, 1'b1, 27, 4'b0111, 7'b0000000, 1'b1};
    tv[20] = '{16'h9876, 4'b0000, 1'b0, 3,  4'b1110, 7'b1011111, 1'b0};
    tv[21] = '{16'h9876, 4'b0000, 1'b0, 11, 4'b1101, 7'b1110000, 1'b0};
    tv[22] = '{16'h9876, 4'b0000, 1'b0, 19, 4'b1011, 7'b1111111, 1'b0};
    tv[23] = '{16'h9876, 4'b0000, 1'b0, 27, 4'b0111, 7'b1110011, 1'b0};
    tv[24] = '{16'hB000, 4'b0000, 1'b1, 27, 4'b0111, SEG_XB,     1'b0};
    tv[25] = '{16'hB000, 4'b0000, 1'b1, 19, 4'b1011, 7'b1111110, 1'b0};

    // Reset followed by a long idle period with no strobe.
    step();
    reset = 1'b1;
    check("reset_state", {display_select, segments, dp, frame_done}, {4'b1111, 7'b0, 1'b0, 1'b0});
    for (int i = 0; i < 100; i++) begin
      step();
      check($sformatf("idle_%0d", i), {display_select, segments, dp, frame_done}, {4'b1111, 7'b0, 1'b0, 1'b0});
    end

    for (int i = 0; i < NV; i++) begin
      load(tv[i].code, tv[i].dpi, tv[i].lz);
      step(tv[i].k);
      check_out($sformatf("vec_%0d", i), tv[i].sel, tv[i].seg, tv[i].d);
    end

    // frame_done: one pulse per 32-cycle frame.
    load(16'h1234, 4'b0000, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      step();
      check($sformatf("frame_done_k%0d", k), {31'b0, frame_done}, {31'b0, k == 32 || k == 64});
    end

    // Strobe in the middle of digit 2's slot.
    load(16'h1234, 4'b0000, 1'b0);
    step(21);
    BCD_code = 16'h1111;
    valid_BCD = 1'b1;
    step();
    valid_BCD = 1'b0;
    check_out("mid_old", 4'b1011, 7'b1101101, 1'b0);
    step();
    check_out("mid_new", 4'b1011, 7'b0110000, 1'b0);
    step();
    check_out("mid_hold", 4'b1011, 7'b0110000, 1'b0);
    step();
    check_out("mid_blank", 4'b1111, 7'b0000000, 1'b0);

    // Strobe coinciding with a slot wrap.
    load(16'h1234, 4'b0000, 1'b0);
    step(7);
    BCD_code = 16'h9999;
    valid_BCD = 1'b1;
    step();
    valid_BCD = 1'b0;
    step(3);
    check_out("wrap_d1", 4'b1101, 7'b1110011, 1'b0);
    step(24);
    check_out("wrap_d0", 4'b1110, 7'b1110011, 1'b0);

    // Reset mid-scan: dark until the next strobe, then restart at digit 0.
    load(16'h1234, 4'b0000, 1'b0);
    step(12);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_out("rst_mid", 4'b1111, 7'b0000000, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step();
      check($sformatf("rst_dark_%0d", i), {display_select, segments, dp, frame_done}, {4'b1111, 7'b0, 1'b0, 1'b0});
    end
    BCD_code = 16'h1234;
    valid_BCD = 1'b1;
    step();
    valid_BCD = 1'b0;
    step();
    check_out("rst_reload_k1", 4'b1111, 7'b0000000, 1'b0);
    step(2);
    check_out("rst_reload_k3", 4'b1110, 7'b0110011, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
